// File: rtl/nn_fixed_pkg.sv
// Fixed-point constants, lane packing helpers and shared types for the
// bias/ReLU output stage of the neural-network datapath.
package nn_fixed_pkg;

  localparam int LANES      = 8;
  localparam int ACC_W      = 32;
  localparam int BIAS_W     = 16;
  localparam int OUT_W      = 16;
  localparam int ACC_FRAC   = 16;
  localparam int BIAS_FRAC  = 8;
  localparam int OUT_FRAC   = 8;
  localparam int NUM_GROUPS = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int LAST_LANES = 2;

  localparam int BIAS_SH = ACC_FRAC - BIAS_FRAC;
  localparam int RND_SH  = ACC_FRAC - OUT_FRAC;
  localparam int SUM_W   = ACC_W + 2;

  typedef logic [ADDR_WIDTH-1:0] grp_t;

  typedef struct packed {
    logic [LANES-1:0] lane_mask;
    logic             last;
  } side_t;

  // Lane 0 occupies the most significant slice of every packed vector.
  function automatic logic [ACC_W-1:0] acc_slice(input logic [LANES*ACC_W-1:0] vec,
                                                 input int lane);
    return vec[ACC_W*(LANES-lane)-1 -: ACC_W];
  endfunction

  function automatic logic [BIAS_W-1:0] bias_slice(input logic [LANES*BIAS_W-1:0] vec,
                                                   input int lane);
    return vec[BIAS_W*(LANES-lane)-1 -: BIAS_W];
  endfunction

  function automatic logic [LANES-1:0] lane_mask_for(input logic is_last);
    logic [LANES-1:0] m;
    m = {LANES{1'b1}};
    if (is_last) begin
      m = {LANES{1'b0}};
      for (int i = 0; i < LAST_LANES; i++) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic grp_t next_grp(input grp_t g);
    return (g == grp_t'(NUM_GROUPS - 1)) ? grp_t'(0) : g + grp_t'(1);
  endfunction

endpackage

// File: rtl/bias_relu_lane.sv
// One lane of the output stage: align bias, add, round half up, ReLU and
// saturate. Purely combinational; the parent registers the result.
module bias_relu_lane
  import nn_fixed_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic                     keep,
  output logic        [OUT_W-1:0]  act
);

  localparam logic signed [SUM_W-1:0] RND_HALF = SUM_W'(1) << (RND_SH - 1);
  localparam logic signed [SUM_W-1:0] SAT_HI   = SUM_W'((1 << (OUT_W - 1)) - 1);

  logic signed [SUM_W-1:0] bias_al_s;
  logic signed [SUM_W-1:0] sum_s;
  logic signed [SUM_W-1:0] rnd_s;

  // Two guard bits keep the sum exact for any accumulator/bias pair.
  assign bias_al_s = {{(SUM_W - BIAS_W){bias[BIAS_W-1]}}, bias} <<< BIAS_SH;
  assign sum_s     = {{(SUM_W - ACC_W){acc[ACC_W-1]}}, acc} + bias_al_s;
  assign rnd_s     = (sum_s + RND_HALF) >>> RND_SH;

  // ReLU clamps negatives to zero, positives clip at the signed output maximum.
  always_comb begin
    act = {OUT_W{1'b0}};
    if (!keep) begin
      act = {OUT_W{1'b0}};
    end else if (rnd_s[SUM_W-1]) begin
      act = {OUT_W{1'b0}};
    end else if (rnd_s > SAT_HI) begin
      act = SAT_HI[OUT_W-1:0];
    end else begin
      act = rnd_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/bias_relu_unit.sv
// Two-stage valid/ready pipeline: stage A captures accumulators while the bias
// ROM is read, stage B registers biased, rounded, ReLU'd activations.
module bias_relu_unit
  import nn_fixed_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      acc_valid,
  output logic                      acc_ready,
  input  logic [LANES*ACC_W-1:0]    acc_data,
  output logic [ADDR_WIDTH-1:0]     bias_addr,
  input  logic [LANES*BIAS_W-1:0]   bias_q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*OUT_W-1:0]    out_data,
  output logic [LANES-1:0]          out_lane_mask,
  output logic                      out_last
);

  localparam grp_t LAST_GRP = grp_t'(NUM_GROUPS - 1);

  grp_t                   in_grp_r;
  grp_t                   grp_a_r;
  logic                   a_valid_r;
  logic [LANES*ACC_W-1:0] acc_a_r;

  logic                   out_valid_r;
  logic [LANES*OUT_W-1:0] out_data_r;
  side_t                  side_r;

  logic                   a_adv_s;
  logic                   accept_s;
  logic                   last_a_s;
  logic [LANES-1:0]       mask_a_s;
  logic [LANES*OUT_W-1:0] act_s;

  assign a_adv_s   = a_valid_r & (~out_valid_r | out_ready);
  assign acc_ready = ~a_valid_r | a_adv_s;
  assign accept_s  = acc_valid & acc_ready;
  assign last_a_s  = (grp_a_r == LAST_GRP);
  assign mask_a_s  = lane_mask_for(last_a_s);

  // A stalled stage A keeps re-reading its own group so bias_q stays aligned.
  always_comb begin
    bias_addr = in_grp_r;
    if (a_valid_r && !a_adv_s) begin
      bias_addr = grp_a_r;
    end else begin
      bias_addr = in_grp_r;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bias_relu_lane u_lane (
      .acc  (acc_slice(acc_a_r, i)),
      .bias (bias_slice(bias_q, i)),
      .keep (mask_a_s[i]),
      .act  (act_s[OUT_W*(LANES-i)-1 -: OUT_W])
    );
  end

  // Stage A capture register and group counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_grp_r  <= grp_t'(0);
      grp_a_r   <= grp_t'(0);
      a_valid_r <= 1'b0;
      acc_a_r   <= {(LANES*ACC_W){1'b0}};
    end else begin
      if (accept_s) begin
        acc_a_r   <= acc_data;
        grp_a_r   <= in_grp_r;
        a_valid_r <= 1'b1;
        in_grp_r  <= next_grp(in_grp_r);
      end else if (a_adv_s) begin
        a_valid_r <= 1'b0;
      end
    end
  end

  // Stage B output register; holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {(LANES*OUT_W){1'b0}};
      side_r      <= '{lane_mask: {LANES{1'b0}}, last: 1'b0};
    end else begin
      if (a_adv_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= act_s;
        side_r      <= '{lane_mask: mask_a_s, last: last_a_s};
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out_valid     = out_valid_r;
  assign out_data      = out_data_r;
  assign out_lane_mask = side_r.lane_mask;
  assign out_last      = side_r.last;

endmodule

// File: tb/tb_bias_relu_unit.sv
// Scoreboard bench for bias_relu_unit with a registered-read bias ROM model.
module tb_bias_relu_unit;
  import nn_fixed_pkg::*;

  typedef struct {
    logic [127:0] data;
    logic [7:0]   mask;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         acc_valid = 1'b0;
  logic         acc_ready;
  logic [255:0] acc_data = '0;
  logic [3:0]   bias_addr;
  logic [127:0] bias_q = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [7:0]   out_lane_mask;
  logic         out_last;

  logic [127:0] rom [16];
  exp_t         sb [$];
  exp_t         mon_e;
  int           exp_grp = 0;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) bias_q <= rom[bias_addr];

  bias_relu_unit dut (
    .clk(clk), .rst_n(rst_n), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .bias_addr(bias_addr), .bias_q(bias_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane_mask(out_lane_mask), .out_last(out_last)
  );

  function automatic logic [15:0] ref_lane(input logic [31:0] a, input logic [15:0] b);
    longint s;
    longint r;
    s = longint'($signed(a)) + longint'($signed(b)) * 64'sd256;
    r = (s + 64'sd128) >>> 8;
    if (r < 64'sd0) return 16'h0000;
    if (r > 64'sd32767) return 16'h7FFF;
    return r[15:0];
  endfunction

  function automatic exp_t make_exp(input logic [255:0] a, input int g);
    exp_t e;
    e.last = (g == 15);
    e.mask = e.last ? 8'b00000011 : 8'hFF;
    e.data = '0;
    for (int i = 0; i < 8; i++)
      if (e.mask[i]) e.data[127-16*i -: 16] = ref_lane(a[255-32*i -: 32], rom[g][127-16*i -: 16]);
    return e;
  endfunction

  function automatic logic [255:0] rvec();
    logic [255:0] v;
    logic [31:0]  r;
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      v[255-32*i -: 32] = (r[1:0] == 2'd0) ? $urandom : 32'($signed(r) >>> 7);
    end
    return v;
  endfunction

  function automatic logic [255:0] mk(input logic [31:0] lane0);
    logic [255:0] v;
    v = rvec();
    v[255:224] = lane0;
    return v;
  endfunction

  // Scoreboard: push on accepted input, pop and compare on each output transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_grp = 0;
    end else begin
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_empty: got beat data=%h, expected no beat", out_data);
        end else begin
          mon_e = sb.pop_front();
          if (out_data !== mon_e.data || out_lane_mask !== mon_e.mask || out_last !== mon_e.last) begin
            bad++;
            $display("FAIL scoreboard: got data=%h mask=%b last=%b, expected data=%h mask=%b last=%b",
                     out_data, out_lane_mask, out_last, mon_e.data, mon_e.mask, mon_e.last);
          end
        end
      end
      if (acc_valid && acc_ready) begin
        sb.push_back(make_exp(acc_data, exp_grp));
        exp_grp = (exp_grp + 1) % 16;
      end
    end
  end

  task automatic idle(input int n);
    acc_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves acc_valid high so consecutive calls stream back to back.
  task automatic send(input logic [255:0] v);
    int n;
    n = 0;
    acc_data = v;
    acc_valid = 1'b1;
    @(negedge clk); #1;
    while (!acc_ready && n < 64) begin
      @(negedge clk); #1;
      n++;
    end
    if (!acc_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: acc_ready=%b after %0d cycles, expected 1", acc_ready, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic one_beat(input logic [255:0] v, output logic vld, output logic [15:0] lane0);
    send(v);
    acc_valid = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    vld = out_valid;
    lane0 = out_data[127:112];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    acc_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 128'h0 || out_lane_mask !== 8'h00 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b data=%h mask=%b last=%b, expected all zero",
               out_valid, out_data, out_lane_mask, out_last);
    end
    total++;
    if (acc_ready !== 1'b1 || bias_addr !== 4'd0) begin
      bad++;
      $display("FAIL reset_input_side: got acc_ready=%b bias_addr=%0d, expected 1 and 0", acc_ready, bias_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    acc_data = mk(32'h0001_0000);
    acc_valid = 1'b1;
    @(negedge clk); #1;
    total++;
    if (bias_addr !== 4'd0 || acc_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_capture: got bias_addr=%0d acc_ready=%b, expected 0 and 1", bias_addr, acc_ready);
    end
    @(posedge clk); #1;
    acc_valid = 1'b0;
    @(negedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_latency_early: got out_valid=%b one cycle after accept, expected 0", out_valid);
    end
    @(negedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_data[127:112] !== 16'h0200) begin
      bad++;
      $display("FAIL basic_add: got valid=%b lane0=%h, expected 1 and 0200", out_valid, out_data[127:112]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_relu();
    logic        v;
    logic [15:0] l0;
    one_beat(mk(32'hFFFF_0000), v, l0);
    total++;
    if (v !== 1'b1 || l0 !== 16'h0000) begin
      bad++;
      $display("FAIL relu_negative: got valid=%b lane0=%h, expected 1 and 0000", v, l0);
    end
    one_beat(mk(32'h0000_0080), v, l0);
    total++;
    if (v !== 1'b1 || l0 !== 16'h0001) begin
      bad++;
      $display("FAIL relu_round_half_up: got valid=%b lane0=%h, expected 1 and 0001", v, l0);
    end
  endtask

  task automatic test_saturation();
    logic        v;
    logic [15:0] l0;
    one_beat(mk(32'h7FFF_FFFF), v, l0);
    total++;
    if (v !== 1'b1 || l0 !== 16'h7FFF) begin
      bad++;
      $display("FAIL sat_positive: got valid=%b lane0=%h, expected 1 and 7fff", v, l0);
    end
    one_beat(mk(32'h8000_0000), v, l0);
    total++;
    if (v !== 1'b1 || l0 !== 16'h0000) begin
      bad++;
      $display("FAIL sat_negative_no_wrap: got valid=%b lane0=%h, expected 1 and 0000", v, l0);
    end
  endtask

  task automatic test_full_pass();
    while (exp_grp != 0) send(rvec());
    idle(4);
    for (int k = 0; k < 19; k++) begin
      if (k <= 16) begin
        acc_data = rvec();
        acc_valid = 1'b1;
      end else begin
        acc_valid = 1'b0;
      end
      @(negedge clk); #1;
      if (k <= 16) begin
        total++;
        if (acc_ready !== 1'b1 || bias_addr !== 4'(k % 16)) begin
          bad++;
          $display("FAIL full_pass_addr: beat %0d got acc_ready=%b bias_addr=%0d, expected 1 and %0d",
                   k, acc_ready, bias_addr, k % 16);
        end
      end
      if (k >= 2) begin
        total++;
        if (out_valid !== 1'b1) begin
          bad++;
          $display("FAIL full_pass_rate: cycle %0d got out_valid=%b, expected 1", k, out_valid);
        end
      end
      if (k == 17) begin
        total++;
        if (out_last !== 1'b1 || out_lane_mask !== 8'b00000011 || out_data[95:0] !== 96'h0) begin
          bad++;
          $display("FAIL full_pass_last: got last=%b mask=%b lanes2to7=%h, expected 1, 00000011, 0",
                   out_last, out_lane_mask, out_data[95:0]);
        end
      end
      if (k == 18) begin
        total++;
        if (out_last !== 1'b0 || out_lane_mask !== 8'hFF) begin
          bad++;
          $display("FAIL full_pass_wrap: got last=%b mask=%b, expected 0 and 11111111", out_last, out_lane_mask);
        end
      end
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  task automatic test_backpressure();
    int           g;
    logic [127:0] held;
    logic         took;
    idle(4);
    g = exp_grp;
    held = '0;
    out_ready = 1'b1;
    acc_data = rvec();
    acc_valid = 1'b1;
    @(negedge clk); #1;
    @(posedge clk); #1;
    acc_data = rvec();
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk); #1;
      took = acc_ready;
      total++;
      if (acc_ready !== ((s == 0) ? 1'b1 : 1'b0) || bias_addr !== 4'(g + 1)) begin
        bad++;
        $display("FAIL stall_ready_addr: stall %0d got acc_ready=%b bias_addr=%0d, expected %b and %0d",
                 s, acc_ready, bias_addr, (s == 0), (g + 1) % 16);
      end
      if (s == 1) held = out_data;
      if (s >= 1) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          bad++;
          $display("FAIL stall_hold: stall %0d got valid=%b data=%h, expected 1 and %h", s, out_valid, out_data, held);
        end
      end
      @(posedge clk); #1;
      if (took) acc_data = rvec();
    end
    out_ready = 1'b1;
    send(acc_data);
    send(rvec());
    idle(6);
  endtask

  task automatic test_reset_midstream();
    while (exp_grp != 7) send(rvec());
    acc_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_data = rvec();
    acc_valid = 1'b1;
    @(negedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || acc_ready !== 1'b1 || bias_addr !== 4'd0) begin
      bad++;
      $display("FAIL reset_midstream: got out_valid=%b acc_ready=%b bias_addr=%0d, expected 0, 1, 0",
               out_valid, acc_ready, bias_addr);
    end
    @(posedge clk); #1;
    idle(6);
  endtask

  initial begin
    for (int g = 0; g < 16; g++)
      for (int i = 0; i < 8; i++)
        rom[g][127-16*i -: 16] = 16'(g * 937 + i * 4111 + 12345);
    rom[0][127:112] = 16'h0100;
    rom[1][127:112] = 16'h0080;
    rom[2][127:112] = 16'h0000;
    rom[3][127:112] = 16'h7FFF;
    rom[4][127:112] = 16'h8000;

    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_full_pass();
    test_backpressure();
    test_reset_midstream();

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d beats still expected, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
